gate_controller: RTL and testbench

- Measurement-window stage directly downstream of pulse_counter: drives its run input for a programmed gate time and consumes its free-running count output.
- Pulse_counter clears only on rst_n, so this block snapshots count at gate open and at gate close and reports the modulo-2^16 difference as pulses-per-gate.
- Result is delivered with a valid/ack handshake to the register/readout logic.

---
 rtl/ppt_pkg.sv | 15 +
 rtl/gate_controller_if.sv | 29 ++
 rtl/gate_tick_gen.sv | 32 +++
 rtl/gate_controller.sv | 135 +++++++++++++
 tb/tb_gate_controller.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/ppt_pkg.sv
// Shared definitions for the pulse-per-gate measurement path:
// default widths, the default tick divider and the gate FSM states.
package ppt_pkg;

  localparam int CNT_W_DEF    = 16;
  localparam int LEN_W_DEF    = 16;
  localparam int TICK_DIV_DEF = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GATE   = 2'd1,
    ST_SETTLE = 2'd2
  } gate_state_e;

endpackage

// File: rtl/gate_controller_if.sv
// Control, counter and result-handshake bundle between the gate controller
// and its neighbours: software control, pulse_counter and readout.
interface gate_controller_if #(
  parameter int CNT_W = ppt_pkg::CNT_W_DEF,
  parameter int LEN_W = ppt_pkg::LEN_W_DEF
) ();

  logic             start;
  logic             abort;
  logic             continuous;
  logic [LEN_W-1:0] gate_len;
  logic [CNT_W-1:0] count_in;
  logic             run;
  logic             busy;
  logic [CNT_W-1:0] result;
  logic             result_valid;
  logic             result_ack;

  modport master (
    output start, abort, continuous, gate_len, count_in, result_ack,
    input  run, busy, result, result_valid
  );

  modport slave (
    input  start, abort, continuous, gate_len, count_in, result_ack,
    output run, busy, result, result_valid
  );

endinterface

// File: rtl/gate_tick_gen.sv
// Enabled prescaler: one-cycle tick every TICK_DIV enabled cycles, restarting
// whenever the enable drops. With TICK_DIV=1 the tick is constantly high.
module gate_tick_gen
  import ppt_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic tick_o
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!en_i || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Counter is held at zero while disabled, so this is low outside a gate when TICK_DIV>1.
  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/gate_controller.sv
// Measurement window for pulse_counter: drives run for gate_len ticks, snapshots
// the free-running count at gate open and close, and hands the difference to readout.
module gate_controller
  import ppt_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int LEN_W    = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  gate_controller_if.slave  gc
);

  gate_state_e      state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] gcnt_q;
  logic             first_q;
  logic [CNT_W-1:0] snap_q;
  logic [CNT_W-1:0] result_q;
  logic             valid_q;
  logic             run_q;
  logic             busy_q;
  logic             tick_en_s;
  logic             tick_s;

  assign tick_en_s = (state_q == ST_GATE);

  gate_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (tick_en_s),
    .tick_o (tick_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      gcnt_q   <= '0;
      first_q  <= 1'b0;
      snap_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // A result write later in this block overrides a same-cycle acknowledge.
      if (gc.result_ack) begin
        valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (gc.start && !gc.abort) begin
            busy_q <= 1'b1;
            if (gc.gate_len != '0) begin
              len_q   <= gc.gate_len;
              gcnt_q  <= '0;
              first_q <= 1'b1;
              run_q   <= 1'b1;
              state_q <= ST_GATE;
            end else begin
              snap_q  <= gc.count_in;
              run_q   <= 1'b0;
              state_q <= ST_SETTLE;
            end
          end else begin
            run_q  <= 1'b0;
            busy_q <= 1'b0;
          end
        end
        ST_GATE: begin
          if (gc.abort) begin
            first_q <= 1'b0;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            // count_in lags run by a cycle, so the first gate cycle still shows the baseline.
            if (first_q) begin
              snap_q  <= gc.count_in;
              first_q <= 1'b0;
            end
            if (tick_s) begin
              if (gcnt_q == (len_q - LEN_W'(1))) begin
                run_q   <= 1'b0;
                state_q <= ST_SETTLE;
              end else begin
                gcnt_q <= gcnt_q + LEN_W'(1);
              end
            end
          end
        end
        ST_SETTLE: begin
          if (gc.abort) begin
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            result_q <= gc.count_in - snap_q;
            valid_q  <= 1'b1;
            if (gc.continuous && (gc.gate_len != '0)) begin
              len_q   <= gc.gate_len;
              gcnt_q  <= '0;
              first_q <= 1'b1;
              run_q   <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= ST_GATE;
            end else if (gc.continuous) begin
              snap_q  <= gc.count_in;
              run_q   <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= ST_SETTLE;
            end else begin
              run_q   <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          run_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gc.run          = run_q;
  assign gc.busy         = busy_q;
  assign gc.result       = result_q;
  assign gc.result_valid = valid_q;

endmodule

// File: tb/tb_gate_controller.sv
// Two gate controllers (TICK_DIV 1 and 4) with shared control, each feeding its own
// pulse-counter stand-in; outputs compared per cycle to a timeline model.
module tb_gate_controller;

  logic        clk;
  logic        rst_n;
  logic        start_s, abort_s, ack_s, inc_s, direct_s;
  logic [1:0]  cont_s;
  logic [15:0] len_s;
  logic [15:0] dval_s [2];
  logic [1:0]  run_w, busy_w, val_w;
  logic [15:0] res_w [2];
  logic        exp_val [2];
  logic [15:0] exp_res [2];
  int          n_vec, n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    gate_controller_if ifc ();
    gate_controller #(.TICK_DIV((g == 0) ? 1 : 4)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .gc    (ifc)
    );
    // Free-running pulse counter stand-in; never cleared, starts near wrap.
    logic [15:0] cnt_q = 16'hFFF0 + 16'(g * 5);
    always @(posedge clk) if (ifc.run && inc_s) cnt_q <= cnt_q + 16'd1;
    assign ifc.start      = start_s;
    assign ifc.abort      = abort_s;
    assign ifc.continuous = cont_s[g];
    assign ifc.gate_len   = len_s;
    assign ifc.result_ack = ack_s;
    assign ifc.count_in   = direct_s ? dval_s[g] : cnt_q;
    assign run_w[g]  = ifc.run;
    assign busy_w[g] = ifc.busy;
    assign val_w[g]  = ifc.result_valid;
    assign res_w[g]  = ifc.result;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dv(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check_val($sformatf("%s run%0d", tag, d), 32'(run_w[d]), 32'd0);
      check_val($sformatf("%s busy%0d", tag, d), 32'(busy_w[d]), 32'd0);
      check_val($sformatf("%s valid%0d", tag, d), 32'(val_w[d]), 32'd0);
      check_val($sformatf("%s result%0d", tag, d), 32'(res_w[d]), 32'd0);
      exp_val[d] = 1'b0;
      exp_res[d] = 16'd0;
    end
  endtask

  // One measurement scenario: start at cycle 0, n ticks, ng gates, abort at cycle ab
  // (0 = with start, -1 = none), direct count_in drive for the wrap case.
  task automatic run_scn(input int n, input int ng, input int ab, input bit dir, input bit ack_on);
    int L [2], endc [2], acc [2], tmax, ph;
    bit busy_e, run_e, settle_e;
    for (int d = 0; d < 2; d++) begin
      L[d]    = n * dv(d);
      endc[d] = (ab == 0) ? 0 : ng * (L[d] + 1);
      if (ab > 0 && ab < endc[d]) endc[d] = ab;
      acc[d]  = 0;
    end
    tmax = endc[1] + 3;
    for (int c = 0; c <= tmax; c++) begin
      @(posedge clk);
      #1;
      direct_s = dir;
      start_s  = (c == 0) || (c <= endc[0] && $urandom_range(3) == 0);
      abort_s  = (c == ab);
      len_s    = 16'(n);
      ack_s    = ack_on && ($urandom_range(3) == 0);
      inc_s    = 1'($urandom_range(1));
      for (int d = 0; d < 2; d++) begin
        cont_s[d] = (ng > 1) && (c < 1 + (ng - 1) * (L[d] + 1));
        dval_s[d] = (c == 1) ? 16'hFFFE : (c == L[d] + 1) ? 16'h0003 : 16'(c * 7);
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        ph       = (c >= 1) ? (c - 1) % (L[d] + 1) : 0;
        busy_e   = (c >= 1) && (c <= endc[d]);
        run_e    = busy_e && (ph < L[d]);
        settle_e = busy_e && (ph == L[d]) && (c != ab);
        check_val($sformatf("run%0d n%0d c%0d", d, n, c), 32'(run_w[d]), 32'(run_e));
        check_val($sformatf("busy%0d n%0d c%0d", d, n, c), 32'(busy_w[d]), 32'(busy_e));
        check_val($sformatf("valid%0d n%0d c%0d", d, n, c), 32'(val_w[d]), 32'(exp_val[d]));
        check_val($sformatf("result%0d n%0d c%0d", d, n, c), 32'(res_w[d]), 32'(exp_res[d]));
        if (run_e && inc_s) acc[d]++;
        if (settle_e) begin
          exp_val[d] = 1'b1;
          exp_res[d] = dir ? 16'h0005 : 16'(acc[d]);
          acc[d]     = 0;
        end else if (ack_s) begin
          exp_val[d] = 1'b0;
        end
      end
    end
    start_s  = 1'b0;
    abort_s  = 1'b0;
    direct_s = 1'b0;
  endtask

  initial begin
    int n, ng, ab, r;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; start_s = 1'b0; abort_s = 1'b0; ack_s = 1'b0; inc_s = 1'b0;
    direct_s = 1'b0; cont_s = 2'b00; len_s = 16'd0;
    dval_s[0] = 16'd0; dval_s[1] = 16'd0;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_scn(10, 1, -1, 1'b0, 1'b1);   // basic gate with pulses
    run_scn(2, 1, -1, 1'b1, 1'b0);    // counter wrap FFFE -> 0003
    run_scn(0, 1, -1, 1'b0, 1'b0);    // zero-length gate
    run_scn(3, 1, -1, 1'b0, 1'b1);
    run_scn(5, 3, -1, 1'b0, 1'b0);    // continuous, no ack
    run_scn(6, 1, 3, 1'b0, 1'b0);     // abort on third gate cycle
    run_scn(4, 1, 0, 1'b0, 1'b0);     // start and abort together in IDLE

    // Asynchronous reset in the middle of a gate.
    @(posedge clk);
    #1;
    start_s = 1'b1; len_s = 16'd6; cont_s = 2'b00;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_val("midgate run", 32'(run_w), 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 30; i++) begin
      n  = int'($urandom_range(8));
      ng = (n == 0) ? 1 : int'($urandom_range(3, 1));
      r  = int'($urandom_range(5));
      ab = (r == 0) ? 0 : (r == 1) ? int'($urandom_range(n + 1, 1)) : -1;
      run_scn(n, ng, ab, 1'b0, 1'($urandom_range(1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
